// File: rtl/vector_accumulator_unit.sv
// Per-chain element-wise vector accumulator with saturating unsigned adds.
// Chains whose accumulate-enable is clear pass vectors through with the same one-cycle latency.
module vector_accumulator_unit #(
    parameter int N = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4,
    parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
    parameter logic [MAX_CHAINS-1:0] INITIAL_FIRMWARE_ACC_EN = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tracing,
    input  logic                          valid_in,
    input  logic                          eof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic [N*DATA_WIDTH-1:0]       vector_in,
    output logic [N*DATA_WIDTH-1:0]       vector_out,
    output logic [$clog2(MAX_CHAINS)-1:0] chainId_out,
    output logic                          valid_out,
    output logic                          eof_out
);
    localparam int CW = $clog2(MAX_CHAINS);
    localparam int VW = N * DATA_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b};
        if (full[DATA_WIDTH]) begin
            sat_add = {DATA_WIDTH{1'b1}};
        end else begin
            sat_add = full[DATA_WIDTH-1:0];
        end
    endfunction

    logic [VW-1:0]         acc_r [MAX_CHAINS];
    logic [MAX_CHAINS-1:0] acc_en_r;
    logic [VW-1:0]         cur_acc_s;
    logic [VW-1:0]         sum_s;
    logic                  accept_s;
    logic                  cfg_hit_s;
    logic [CW-1:0]         cfg_chain_s;
    logic                  cfg_unused_s;

    assign accept_s     = valid_in & tracing;
    assign cfg_hit_s    = (configId == PERSONAL_CONFIG_ID);
    assign cfg_chain_s  = configData[CW-1:0];
    assign cfg_unused_s = ^configData[6:CW];
    assign cur_acc_s    = acc_r[chainId_in];

    // Saturating element-wise sum of the selected chain's accumulator and the incoming vector.
    always_comb begin
        sum_s = {VW{1'b0}};
        for (int k = 0; k < N; k++) begin
            sum_s[k*DATA_WIDTH +: DATA_WIDTH] = sat_add(cur_acc_s[k*DATA_WIDTH +: DATA_WIDTH],
                                                        vector_in[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Accumulator state, output register and configuration; a config write lands after the
    // input update so it wins on the targeted accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_CHAINS; i++) begin
                acc_r[i] <= {VW{1'b0}};
            end
            acc_en_r    <= INITIAL_FIRMWARE_ACC_EN;
            vector_out  <= {VW{1'b0}};
            chainId_out <= {CW{1'b0}};
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            eof_out   <= 1'b0;
            if (accept_s) begin
                if (acc_en_r[chainId_in]) begin
                    if (eof_in) begin
                        vector_out          <= sum_s;
                        chainId_out         <= chainId_in;
                        valid_out           <= 1'b1;
                        eof_out             <= 1'b1;
                        acc_r[chainId_in]   <= {VW{1'b0}};
                    end else begin
                        acc_r[chainId_in]   <= sum_s;
                    end
                end else begin
                    vector_out  <= vector_in;
                    chainId_out <= chainId_in;
                    valid_out   <= 1'b1;
                    eof_out     <= eof_in;
                end
            end
            if (cfg_hit_s) begin
                acc_en_r[cfg_chain_s] <= configData[7];
                acc_r[cfg_chain_s]    <= {VW{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_vector_accumulator_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from an arithmetic reference model,
// an independent monitor pops and compares whenever the DUT presents an output.
module tb_vector_accumulator_unit;
    localparam int N  = 8;
    localparam int DW = 8;
    localparam int MC = 4;
    localparam int VW = N * DW;
    localparam logic [7:0]    CFG_ID  = 8'h00;
    localparam logic [7:0]    NO_CFG  = 8'hFF;
    localparam logic [MC-1:0] INIT_EN = 4'b0001;

    logic          clk = 1'b0;
    logic          reset, tracing, valid_in, eof_in;
    logic [1:0]    chainId_in, chainId_out;
    logic [7:0]    configId, configData;
    logic [VW-1:0] vector_in, vector_out;
    logic          valid_out, eof_out;

    typedef struct {
        logic [VW-1:0] vec;
        int            ch;
        bit            eof;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   m_acc[MC][N];
    bit   m_en[MC];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    vector_accumulator_unit #(
        .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC),
        .PERSONAL_CONFIG_ID(CFG_ID), .INITIAL_FIRMWARE_ACC_EN(INIT_EN)
    ) dut (
        .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in), .eof_in(eof_in),
        .chainId_in(chainId_in), .configId(configId), .configData(configData),
        .vector_in(vector_in), .vector_out(vector_out), .chainId_out(chainId_out),
        .valid_out(valid_out), .eof_out(eof_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [VW-1:0] rep(input int b);
        logic [VW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = 8'(b);
        return r;
    endfunction

    // Drive one cycle of inputs at a falling edge, apply the window rules to the model,
    // then return at the next falling edge with that cycle's output visible.
    task automatic step(input bit v, input bit e, input int ch, input logic [VW-1:0] vec,
                        input logic [7:0] cid, input logic [7:0] cdat, input bit tr, input bit rs);
        exp_t x;
        int   s;
        reset = rs; tracing = tr; valid_in = v; eof_in = e; chainId_in = 2'(ch);
        vector_in = vec; configId = cid; configData = cdat;
        if (rs) begin
            for (int i = 0; i < MC; i++) begin
                m_en[i] = INIT_EN[i];
                for (int k = 0; k < N; k++) m_acc[i][k] = 0;
            end
        end else begin
            if (v && tr) begin
                x.ch  = ch;
                x.cyc = cyc + 1;
                if (m_en[ch]) begin
                    x.vec = '0;
                    for (int k = 0; k < N; k++) begin
                        s = m_acc[ch][k] + int'(vec[k*DW +: DW]);
                        if (s > 255) s = 255;
                        m_acc[ch][k] = s;
                        x.vec[k*DW +: DW] = 8'(s);
                    end
                    if (e) begin
                        x.eof = 1'b1;
                        sb.push_back(x);
                        for (int k = 0; k < N; k++) m_acc[ch][k] = 0;
                    end
                end else begin
                    x.vec = vec;
                    x.eof = e;
                    sb.push_back(x);
                end
            end
            if (cid == CFG_ID) begin
                m_en[cdat[1:0]] = cdat[7];
                for (int k = 0; k < N; k++) m_acc[cdat[1:0]][k] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic feed(input int ch, input logic [VW-1:0] vec, input bit e);
        step(1'b1, e, ch, vec, NO_CFG, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic cfg(input logic [7:0] d);
        step(1'b0, 1'b0, 0, '0, CFG_ID, d, 1'b1, 1'b0);
    endtask

    // Monitor: pop on every valid output, otherwise check hold behaviour and that nothing is overdue.
    initial begin : monitor
        bit            armed = 1'b0;
        bit            rs;
        logic [VW-1:0] last_vec;
        int            last_ch;
        exp_t          x;
        forever begin
            @(posedge clk);
            rs = reset;
            #1;
            if (rs) begin
                armed = 1'b1;
                last_vec = '0;
                last_ch = 0;
                chk("rst_valid", VW'(valid_out), '0);
                chk("rst_eof", VW'(eof_out), '0);
                chk("rst_vec", vector_out, '0);
                chk("rst_chain", VW'(chainId_out), '0);
            end else if (armed) begin
                if (valid_out === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_valid: got vec %0h chain %0d, expected no output", vector_out, chainId_out);
                    end else begin
                        x = sb.pop_front();
                        chk("out_cycle", VW'(cyc), VW'(x.cyc));
                        chk("out_vec", vector_out, x.vec);
                        chk("out_chain", VW'(chainId_out), VW'(x.ch));
                        chk("out_eof", VW'(eof_out), VW'(x.eof));
                        last_vec = x.vec;
                        last_ch = x.ch;
                    end
                end else begin
                    chk("idle_valid", VW'(valid_out), '0);
                    chk("idle_eof", VW'(eof_out), '0);
                    chk("hold_vec", vector_out, last_vec);
                    chk("hold_chain", VW'(chainId_out), VW'(last_ch));
                    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                        n_checks++;
                        $display("FAIL missing_output: got no valid, expected vec %0h chain %0d", sb[0].vec, sb[0].ch);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; tracing = 1'b0; valid_in = 1'b0; eof_in = 1'b0; chainId_in = 2'd0;
        vector_in = '0; configId = NO_CFG; configData = 8'h00;
        @(negedge clk);
        step(1'b0, 1'b0, 0, '0, NO_CFG, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, '0, NO_CFG, 8'h00, 1'b0, 1'b1);

        // Pass-through on chain 1
        feed(1, rep(5), 1'b0);
        chk("pt_vec0", vector_out, rep(5));
        chk("pt_eof0", VW'(eof_out), '0);
        feed(1, rep(7), 1'b1);
        chk("pt_vec1", vector_out, rep(7));
        chk("pt_eof1", VW'(eof_out), VW'(1));
        chk("pt_chain", VW'(chainId_out), VW'(1));

        // Accumulate [1..8] three times on chain 0
        cfg(8'h80);
        feed(0, 64'h0807060504030201, 1'b0);
        chk("acc_nv0", VW'(valid_out), '0);
        feed(0, 64'h0807060504030201, 1'b0);
        chk("acc_nv1", VW'(valid_out), '0);
        feed(0, 64'h0807060504030201, 1'b1);
        chk("acc_sum", vector_out, 64'h1815120f0c090603);
        chk("acc_chain", VW'(chainId_out), '0);

        // Interleave chains 0 and 2
        cfg(8'h82);
        for (int i = 0; i < 4; i++) begin
            feed(0, rep(1), i == 3);
            if (i == 3) chk("il_c0", vector_out, rep(4));
            feed(2, rep(10), i == 3);
            if (i == 3) begin
                chk("il_c2", vector_out, rep(40));
                chk("il_c2_chain", VW'(chainId_out), VW'(2));
            end
        end

        // Saturation then a single-vector window
        feed(0, rep(200), 1'b0);
        feed(0, rep(100), 1'b1);
        chk("sat_255", vector_out, rep(255));
        feed(0, rep(3), 1'b1);
        chk("sat_clear", vector_out, rep(3));

        // Tracing gap keeps the partial sum
        feed(0, rep(2), 1'b0);
        step(1'b1, 1'b0, 0, rep(50), NO_CFG, 8'h00, 1'b0, 1'b0);
        feed(0, rep(4), 1'b1);
        chk("trace_gap", vector_out, rep(6));

        // Reset mid-window drops the partial sum
        feed(0, rep(2), 1'b0);
        step(1'b0, 1'b0, 0, '0, NO_CFG, 8'h00, 1'b1, 1'b1);
        chk("rst_mid_vec", vector_out, '0);
        chk("rst_mid_valid", VW'(valid_out), '0);
        feed(0, rep(4), 1'b1);
        chk("rst_mid_sum", vector_out, rep(4));

        // Config write collides with an input on the same chain
        step(1'b1, 1'b0, 0, rep(9), CFG_ID, 8'h80, 1'b1, 1'b0);
        chk("coll_nv", VW'(valid_out), '0);
        feed(0, rep(1), 1'b0);
        feed(0, rep(2), 1'b1);
        chk("coll_sum", vector_out, rep(3));

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            logic [VW-1:0] v;
            logic [7:0]    cid;
            for (int k = 0; k < N; k++)
                v[k*DW +: DW] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                             : 8'($urandom_range(0, 40));
            cid = ($urandom_range(0, 14) == 0) ? CFG_ID : 8'($urandom_range(1, 255));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)), v,
                 cid, 8'($urandom), $urandom_range(0, 9) != 0, 1'b0);
        end

        step(1'b0, 1'b0, 0, '0, NO_CFG, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, '0, NO_CFG, 8'h00, 1'b1, 1'b0);
        chk("sb_drained", VW'(sb.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
